link_frame_sync: RTL and testbench

- Downstream of the four-link word aligner. Consumes its four 20-bit aligned words and its slip pulse.
- Per link: searches for a periodic sync word, qualifies it over several frames, then tracks lock with hysteresis.
- Drives the aligner's sync input high only while all four links are locked. While sync is low, the aligner keeps slipping until alignment is found.

---
 rtl/link_frame_sync_pkg.sv | 20 ++
 rtl/link_frame_sync_lane.sv | 140 ++++++++++++++
 rtl/link_frame_sync.sv | 69 ++++++
 tb/tb_link_frame_sync.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/link_frame_sync_pkg.sv
// Shared definitions for the four-lane frame synchroniser: lane state encoding,
// default framing word and counter sizing helper.
package link_frame_sync_pkg;

  localparam int WORD_W = 20;
  localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 20'h3E0F8;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    HUNT   = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } lane_state_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/link_frame_sync_lane.sv
// One lane of frame synchronisation: sync-word compare, frame counter,
// qualification and hysteresis counters.
//
//   state  | meaning
//   BLANK  | settling after reset or aligner slip, hits ignored
//   HUNT   | waiting for any sync word
//   VERIFY | counting consecutive on-time sync words
//   LOCKED | frame tracked, counting consecutive misses
module link_lane_lock
  import link_frame_sync_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int FRAME_LEN = 16,
  parameter int LOCK_CNT  = 4,
  parameter int LOSS_CNT  = 8,
  parameter int SETTLE    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              align_rst,
  input  logic [WORD_W-1:0] data,
  output logic              lock,
  output logic              frame_start
);

  localparam int FW = $clog2(FRAME_LEN);
  localparam int GW = cnt_w(LOCK_CNT);
  localparam int BW = cnt_w(LOSS_CNT);
  localparam int SW = cnt_w(SETTLE);

  localparam logic [FW-1:0] F_LAST = FW'(FRAME_LEN - 1);
  localparam logic [FW-1:0] F_ONE  = FW'(1);
  localparam logic [GW-1:0] G_ONE  = GW'(1);
  localparam logic [GW-1:0] G_DONE = GW'(LOCK_CNT);
  localparam logic [BW-1:0] B_DONE = BW'(LOSS_CNT);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE - 1);

  lane_state_t   state, state_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt, fcnt_inc;
  logic [GW-1:0] good, good_nxt, good_inc;
  logic [BW-1:0] bad, bad_nxt, bad_inc;
  logic [SW-1:0] scnt, scnt_nxt;
  logic          fs_nxt;
  logic          hit;
  logic          at_zero;

  assign hit      = (data == SYNC_WORD);
  assign at_zero  = (fcnt == '0);
  assign fcnt_inc = (fcnt == F_LAST) ? '0 : fcnt + 1'b1;
  assign good_inc = good + 1'b1;
  assign bad_inc  = bad + 1'b1;
  assign lock     = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BLANK;
      fcnt        <= '0;
      good        <= '0;
      bad         <= '0;
      scnt        <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      fcnt        <= fcnt_nxt;
      good        <= good_nxt;
      bad         <= bad_nxt;
      scnt        <= scnt_nxt;
      frame_start <= fs_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    good_nxt  = good;
    bad_nxt   = bad;
    scnt_nxt  = scnt;
    fs_nxt    = 1'b0;
    // A slip invalidates everything this lane has learned, including a hit
    // arriving in the same cycle.
    if (align_rst) begin
      state_nxt = BLANK;
      fcnt_nxt  = '0;
      good_nxt  = '0;
      bad_nxt   = '0;
      scnt_nxt  = '0;
    end else begin
      unique case (state)
        BLANK: begin
          if (scnt == S_LAST) begin
            state_nxt = HUNT;
            scnt_nxt  = '0;
          end else begin
            scnt_nxt = scnt + 1'b1;
          end
        end
        HUNT: begin
          if (hit) begin
            state_nxt = VERIFY;
            fcnt_nxt  = F_ONE;
            good_nxt  = G_ONE;
            bad_nxt   = '0;
          end
        end
        VERIFY: begin
          fcnt_nxt = fcnt_inc;
          if (hit && at_zero) begin
            fs_nxt   = 1'b1;
            good_nxt = good_inc;
            if (good_inc == G_DONE) begin
              state_nxt = LOCKED;
              bad_nxt   = '0;
            end
          end else if (hit) begin
            // An early sync word is taken as a new frame phase, not a failure.
            fcnt_nxt = F_ONE;
            good_nxt = G_ONE;
          end else if (at_zero) begin
            state_nxt = HUNT;
          end
        end
        LOCKED: begin
          fcnt_nxt = fcnt_inc;
          if (at_zero) begin
            if (hit) begin
              fs_nxt  = 1'b1;
              bad_nxt = '0;
            end else begin
              bad_nxt = bad_inc;
              if (bad_inc == B_DONE) begin
                state_nxt = HUNT;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/link_frame_sync.sv
// Frame synchroniser behind the four-link word aligner: four lane trackers,
// a one-register data path and the all-locked sync back to the aligner.
module link_frame_sync
  import link_frame_sync_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int FRAME_LEN = 16,
  parameter int LOCK_CNT  = 4,
  parameter int LOSS_CNT  = 8,
  parameter int SETTLE    = 3
) (
  input  logic              iSclk,
  input  logic              iRstN,
  input  logic [WORD_W-1:0] iD_Link1,
  input  logic [WORD_W-1:0] iD_Link2,
  input  logic [WORD_W-1:0] iD_Link3,
  input  logic [WORD_W-1:0] iD_Link4,
  input  logic              iAlignRst,
  output logic              oSync,
  output logic [3:0]        oLock,
  output logic [3:0]        oFrameStart,
  output logic [WORD_W-1:0] oD_Link1,
  output logic [WORD_W-1:0] oD_Link2,
  output logic [WORD_W-1:0] oD_Link3,
  output logic [WORD_W-1:0] oD_Link4
);

  logic [WORD_W-1:0] lane_data [4];

  assign lane_data[0] = iD_Link1;
  assign lane_data[1] = iD_Link2;
  assign lane_data[2] = iD_Link3;
  assign lane_data[3] = iD_Link4;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    link_lane_lock #(
      .SYNC_WORD (SYNC_WORD),
      .FRAME_LEN (FRAME_LEN),
      .LOCK_CNT  (LOCK_CNT),
      .LOSS_CNT  (LOSS_CNT),
      .SETTLE    (SETTLE)
    ) u_lane (
      .clk         (iSclk),
      .rst_n       (iRstN),
      .align_rst   (iAlignRst),
      .data        (lane_data[i]),
      .lock        (oLock[i]),
      .frame_start (oFrameStart[i])
    );
  end

  // Data is delayed one register so it lines up with oFrameStart.
  always_ff @(posedge iSclk) begin
    if (!iRstN) begin
      oSync    <= 1'b0;
      oD_Link1 <= '0;
      oD_Link2 <= '0;
      oD_Link3 <= '0;
      oD_Link4 <= '0;
    end else begin
      oSync    <= &oLock;
      oD_Link1 <= iD_Link1;
      oD_Link2 <= iD_Link2;
      oD_Link3 <= iD_Link3;
      oD_Link4 <= iD_Link4;
    end
  end

endmodule

// File: tb/tb_link_frame_sync.sv
// Directed bench for link_frame_sync: lock acquisition, early sync restart,
// loss hysteresis, aligner slip blanking and mid-verify reset.
module tb_link_frame_sync;

  localparam logic [19:0] SYNC = 20'h3E0F8;

  logic        iSclk = 1'b0;
  logic        iRstN;
  logic        iAlignRst;
  logic [19:0] iD_Link1, iD_Link2, iD_Link3, iD_Link4;
  logic        oSync;
  logic [3:0]  oLock, oFrameStart;
  logic [19:0] oD_Link1, oD_Link2, oD_Link3, oD_Link4;

  int          total = 0;
  int          bad   = 0;
  int          ncyc  = 0;
  logic [19:0] last_d [4];
  logic [3:0]  m;

  always #5 iSclk = ~iSclk;

  link_frame_sync dut (
    .iSclk       (iSclk),
    .iRstN       (iRstN),
    .iD_Link1    (iD_Link1),
    .iD_Link2    (iD_Link2),
    .iD_Link3    (iD_Link3),
    .iD_Link4    (iD_Link4),
    .iAlignRst   (iAlignRst),
    .oSync       (oSync),
    .oLock       (oLock),
    .oFrameStart (oFrameStart),
    .oD_Link1    (oD_Link1),
    .oD_Link2    (oD_Link2),
    .oD_Link3    (oD_Link3),
    .oD_Link4    (oD_Link4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive one word per link (sync word where hit bit set) for one clock,
  // then return 1 time unit after the edge for sampling.
  task automatic cyc(input logic [3:0] hit, input logic ar);
    logic [19:0] w [4];
    for (int i = 0; i < 4; i++) begin
      w[i] = hit[i] ? SYNC : {4'(4 + i), ncyc[15:0]};
      last_d[i] = w[i];
    end
    iD_Link1  = w[0];
    iD_Link2  = w[1];
    iD_Link3  = w[2];
    iD_Link4  = w[3];
    iAlignRst = ar;
    @(posedge iSclk);
    #1;
    ncyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(4'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRstN = 1'b0; iAlignRst = 1'b0;
    iD_Link1 = '0; iD_Link2 = '0; iD_Link3 = '0; iD_Link4 = '0;

    // reset, with sync words present on the second reset edge
    cyc(4'h0, 1'b0);
    cyc(4'hF, 1'b0);
    chk("rst_lock", oLock, 4'h0);
    chk("rst_sync", oSync, 1'b0);
    chk("rst_fs", oFrameStart, 4'h0);
    chk("rst_data", oD_Link1, 20'h0);
    iRstN = 1'b1;

    // settle window: sync words must be ignored
    repeat (3) cyc(4'hF, 1'b0);
    chk("blank_fs", oFrameStart, 4'h0);
    chk("blank_lock", oLock, 4'h0);

    // acquisition with sync every 16 words on all links
    for (int c = 0; c < 80; c++) begin
      cyc((c % 16 == 0) ? 4'hF : 4'h0, 1'b0);
      if (c == 0) begin
        chk("hunt_fs", oFrameStart, 4'h0);
        chk("hunt_data", oD_Link1, SYNC);
      end
      if (c == 16) begin
        chk("ver_fs", oFrameStart, 4'hF);
        chk("ver_data", oD_Link2, SYNC);
        chk("ver_lock", oLock, 4'h0);
      end
      if (c == 17) begin
        chk("data_dly", oD_Link2, last_d[1]);
        chk("fs_pulse", oFrameStart, 4'h0);
      end
      if (c == 32) chk("good3_lock", oLock, 4'h0);
      if (c == 48) begin
        chk("lock_all", oLock, 4'hF);
        chk("lock_sync_lat", oSync, 1'b0);
      end
      if (c == 49) chk("sync_on", oSync, 1'b1);
      if (c == 64) begin
        chk("lock_fs", oFrameStart, 4'hF);
        chk("lock_data", oD_Link4, SYNC);
      end
    end

    // link 2 silent for 7 frames, then restored: lock held
    for (int f = 0; f < 7; f++) begin
      cyc(4'hD, 1'b0);
      chk("miss7_lock", oLock, 4'hF);
      chk("miss_fs", oFrameStart, 4'hD);
      idle(15);
    end
    cyc(4'hF, 1'b0);
    chk("restore_lock", oLock, 4'hF);
    chk("restore_sync", oSync, 1'b1);
    idle(15);

    // aligner slip with a sync word on the same cycle
    cyc(4'hF, 1'b1);
    chk("ar_lock", oLock, 4'h0);
    chk("ar_fs", oFrameStart, 4'h0);
    chk("ar_sync", oSync, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(4'hF, 1'b0);
      chk("ar_blank_lock", oLock, 4'h0);
      chk("ar_blank_fs", oFrameStart, 4'h0);
    end
    chk("ar_sync_off", oSync, 1'b0);
    idle(15);
    for (int f = 0; f < 4; f++) begin
      cyc(4'hF, 1'b0);
      if (f == 0) chk("ar_hunt_fs", oFrameStart, 4'h0);
      chk("ar_relock", oLock, (f == 3) ? 4'hF : 4'h0);
      idle(15);
    end
    chk("ar_resync", oSync, 1'b1);

    // link 2 silent for 8 frames: lane 2 drops on the 8th miss
    for (int f = 0; f < 8; f++) begin
      cyc(4'hD, 1'b0);
      chk("loss_lock", oLock, (f == 7) ? 4'hD : 4'hF);
      if (f == 7) chk("loss_sync_hold", oSync, 1'b1);
      else idle(15);
    end
    cyc(4'h0, 1'b0);
    chk("loss_sync_drop", oSync, 1'b0);
    idle(14);

    // lane 2 into VERIFY, then a one-cycle reset
    cyc(4'hF, 1'b0);
    chk("s5_lock", oLock, 4'hD);
    idle(19);
    iRstN = 1'b0;
    cyc(4'hF, 1'b0);
    chk("mid_rst_lock", oLock, 4'h0);
    chk("mid_rst_sync", oSync, 1'b0);
    chk("mid_rst_fs", oFrameStart, 4'h0);
    chk("mid_rst_data", oD_Link3, 20'h0);
    iRstN = 1'b1;

    // slip during blanking restarts the settle count
    cyc(4'h0, 1'b0);
    cyc(4'h0, 1'b1);
    cyc(4'h0, 1'b0);
    cyc(4'h0, 1'b0);
    cyc(4'hF, 1'b0);
    chk("ext_blank_fs", oFrameStart, 4'h0);
    idle(15);

    // link 3 sync jumps to phase 5 while verifying
    for (int c = 0; c < 71; c++) begin
      m = (c % 16 == 0) ? 4'b1011 : 4'b0000;
      if ((c < 21) ? (c % 16 == 0) : ((c - 21) % 16 == 0)) m[2] = 1'b1;
      cyc(m, 1'b0);
      if (c == 0) chk("s6_hunt_fs", oFrameStart, 4'h0);
      if (c == 16) chk("s6_ver_fs", oFrameStart, 4'hF);
      if (c == 21) begin
        chk("s6_shift_fs", oFrameStart, 4'h0);
        chk("s6_shift_lock", oLock, 4'h0);
      end
      if (c == 37) chk("s6_restart_fs", oFrameStart, 4'b0100);
      if (c == 48) begin
        chk("s6_lock3", oLock, 4'b1011);
        chk("s6_sync_wait", oSync, 1'b0);
      end
      if (c == 53) chk("s6_l3_pending", oLock, 4'b1011);
      if (c == 69) begin
        chk("s6_lock_all", oLock, 4'hF);
        chk("s6_sync_lat", oSync, 1'b0);
      end
      if (c == 70) chk("s6_sync_on", oSync, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
